grid_iter_ctrl: RTL and testbench
=================================

Name: grid_iter_ctrl

Overview:
- Iteration sequencer that drives the Load/Shift controls of an array of gridcellREGALU cells.
- Consumes each cell's OLD_VAL/NEW_VAL pair and computes the per-iteration residual, i.e. the maximum unsigned |NEW−OLD| across all cells.
- Repeats relaxation steps until the residual is at or below a threshold, or until an iteration budget is exhausted.
- Sits directly downstream of the cell array and upstream of host/readout logic.

Parameters:
- NCELLS, 4, number of cells monitored; the value buses are packed NCELLS×8 bits.
- SETTLE_CYCLES, 2, cycles waited after Load/commit before Shift, covering the cell ALU tick settle time; must be ≥1.
- ITER_W, 16, width of the iteration counter and of MaxIter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin a run; sampled only in IDLE or DONE.
- Abort  in  1  synchronous cancel; return to IDLE.
- Threshold  in  8  convergence limit, unsigned.
- MaxIter  in  ITER_W  iteration budget, unsigned.
- OLD_VALS  in  NCELLS*8  packed OLD_VAL outputs; cell i is at [8i+7:8i].
- NEW_VALS  in  NCELLS*8  packed NEW_VAL outputs, same packing.
- Load  out  1  parallel-load strobe to all cells.
- Shift  out  1  shift/commit strobe to all cells.
- Busy  out  1  high in every state except IDLE and DONE.
- Done  out  1  run finished; held until Start or Abort.
- Converged  out  1  valid while Done=1; 1 means the residual met Threshold.
- IterCount  out  ITER_W  number of Shift strobes issued in the current run.
- MaxDelta  out  8  residual registered at the most recent CHECK.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, and Load, Shift, Busy, Done, Converged, IterCount, MaxDelta all = 0.
- States: IDLE, LOAD, SETTLE, SHIFT, CHECK, DONE.
- All outputs are registered; Load and Shift are decoded from the registered state and are single-cycle strobes.
- IDLE: on Start=1, clear IterCount, MaxDelta and Converged, then go to LOAD.
- LOAD: Load=1 for exactly one cycle.
  - If MaxIter==0, go to DONE with Converged=0 and IterCount=0.
  - Otherwise go to SETTLE with the settle counter=SETTLE_CYCLES−1.
- SETTLE: count down; when the count reaches 0, go to SHIFT. Dwell is exactly SETTLE_CYCLES cycles.
- SHIFT: Shift=1 for one cycle; IterCount increments by 1; go to CHECK.
- CHECK (one cycle):
  - Residual D = max over i of |NEW_i − OLD_i|, each term computed as 8-bit unsigned absolute difference with no wrap (NEW<OLD gives OLD−NEW).
  - MaxDelta ← D.
  - If D ≤ Threshold: go to DONE with Converged=1. This test takes priority over the budget test.
  - Else if IterCount == MaxIter: go to DONE with Converged=0.
  - Else go to SETTLE with the counter reloaded.
- DONE: Done=1 and Busy=0. Start=1 clears Done and Converged and goes to LOAD, which restarts the run.
- Timing from the Start-sampling edge at cycle 0:
  - Load high in cycle 1.
  - First Shift in cycle 2+SETTLE_CYCLES.
  - First CHECK in cycle 3+SETTLE_CYCLES.
  - Each further iteration takes SETTLE_CYCLES+2 cycles.
- Abort=1 in any state: next state IDLE; Load, Shift, Done, Converged → 0. IterCount and MaxDelta hold for inspection. Abort wins over a simultaneous Start.
- Start while Busy=1: ignored.
- Inputs are sampled only in CHECK. Threshold and MaxIter changes mid-run take effect at the next CHECK.
- IterCount cannot overflow, because the run terminates at MaxIter. MaxIter = 2^ITER_W−1 is legal.
- Reset asserted mid-run: immediate return to the reset values; Load/Shift must not glitch high after the reset edge.

Test Plan:
- Reset, then Start with Threshold=0, MaxIter=10, NCELLS=4, all OLD=NEW=0x40 → Load in cycle 1, Shift in cycle 4, CHECK gives MaxDelta=0, Done=1, Converged=1, IterCount=1.
- Deltas per cell {3, 0xF0 vs 0x10 (delta 0xE0), 5, 0}, Threshold=0x20, held constant, MaxIter=3 → MaxDelta=0xE0, three Shifts exactly 4 cycles apart, Done=1, Converged=0, IterCount=3.
- NEW=0x05 vs OLD=0x0A (NEW<OLD) with Threshold=5 → MaxDelta=5, Converged=1 (boundary equality passes).
- MaxIter=0 → a single Load pulse, no Shift, Done=1, Converged=0, IterCount=0, reached in cycle 2.
- Abort asserted in the SETTLE of iteration 2 together with Start=1 → IDLE next cycle, no further Shift, Done=0, IterCount=1 holds.
- Reset driven low for one cycle mid-SHIFT, asynchronously between edges → all outputs 0 immediately; Start afterwards restarts cleanly with Load at cycle 1.

Source files
------------

// File: rtl/grid_iter_ctrl.sv
// Relaxation sequencer for a gridcellREGALU array: issues Load/Shift strobes,
// tracks the max |NEW-OLD| residual and stops on convergence or iteration budget.
module grid_iter_ctrl #(
  parameter int unsigned NCELLS        = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ITER_W        = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic [7:0]            Threshold,
  input  logic [ITER_W-1:0]     MaxIter,
  input  logic [NCELLS*8-1:0]   OLD_VALS,
  input  logic [NCELLS*8-1:0]   NEW_VALS,
  output logic                  Load,
  output logic                  Shift,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Converged,
  output logic [ITER_W-1:0]     IterCount,
  output logic [7:0]            MaxDelta
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_RELOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SHIFT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [SW-1:0]     settle_q;
  logic [ITER_W-1:0] iter_q;
  logic [7:0]        delta_q;
  logic              conv_q;

  logic [7:0]        residual_d;
  logic [7:0]        old_b;
  logic [7:0]        new_b;
  logic [7:0]        diff;

  // Unsigned absolute difference per cell, reduced by max.
  always_comb begin
    residual_d = '0;
    old_b      = '0;
    new_b      = '0;
    diff       = '0;
    for (int unsigned i = 0; i < NCELLS; i++) begin
      old_b = OLD_VALS[8*i +: 8];
      new_b = NEW_VALS[8*i +: 8];
      diff  = (new_b >= old_b) ? (new_b - old_b) : (old_b - new_b);
      if (diff > residual_d) residual_d = diff;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      iter_q   <= '0;
      delta_q  <= '0;
      conv_q   <= 1'b0;
    end else if (Abort) begin
      // IterCount and MaxDelta are deliberately left for inspection.
      state_q <= S_IDLE;
      conv_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            iter_q  <= '0;
            delta_q <= '0;
            conv_q  <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (MaxIter == '0) begin
            conv_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            settle_q <= SETTLE_RELOAD;
            state_q  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) state_q <= S_SHIFT;
          else                settle_q <= settle_q - 1'b1;
        end
        S_SHIFT: begin
          iter_q  <= iter_q + 1'b1;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          delta_q <= residual_d;
          if (residual_d <= Threshold) begin
            conv_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (iter_q == MaxIter) begin
            conv_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            settle_q <= SETTLE_RELOAD;
            state_q  <= S_SETTLE;
          end
        end
        S_DONE: begin
          if (Start) begin
            iter_q  <= '0;
            conv_q  <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Load      = (state_q == S_LOAD);
  assign Shift     = (state_q == S_SHIFT);
  assign Busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign Done      = (state_q == S_DONE);
  assign Converged = conv_q;
  assign IterCount = iter_q;
  assign MaxDelta  = delta_q;

endmodule

// File: tb/tb_grid_iter_ctrl.sv
// Directed bench for grid_iter_ctrl (NCELLS=4, SETTLE_CYCLES=2, ITER_W=16).
module tb_grid_iter_ctrl;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Abort;
  logic [7:0]  Threshold;
  logic [15:0] MaxIter;
  logic [31:0] OLD_VALS;
  logic [31:0] NEW_VALS;
  logic        Load;
  logic        Shift;
  logic        Busy;
  logic        Done;
  logic        Converged;
  logic [15:0] IterCount;
  logic [7:0]  MaxDelta;

  int vec  = 0;
  int miss = 0;

  int load_cnt;
  int first_load;
  int shift_n;
  int shift_cyc [8];
  int done_cyc;

  grid_iter_ctrl #(.NCELLS(4), .SETTLE_CYCLES(2), .ITER_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .Threshold(Threshold), .MaxIter(MaxIter),
    .OLD_VALS(OLD_VALS), .NEW_VALS(NEW_VALS),
    .Load(Load), .Shift(Shift), .Busy(Busy), .Done(Done),
    .Converged(Converged), .IterCount(IterCount), .MaxDelta(MaxDelta)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Called at a negedge. Start is sampled at edge 0; cycle n is observed at the
  // negedge before edge n. Returns at the negedge of the stop cycle or when Done.
  task automatic run(input int stop_cyc);
    load_cnt = 0; first_load = -1; shift_n = 0; done_cyc = -1;
    Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    for (int cyc = 1; cyc <= stop_cyc; cyc++) begin
      @(negedge Clk);
      if (Load) begin
        load_cnt++;
        if (first_load < 0) first_load = cyc;
      end
      if (Shift && shift_n < 8) begin
        shift_cyc[shift_n] = cyc;
        shift_n++;
      end
      if (Done) begin
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0;
    Threshold = '0; MaxIter = '0; OLD_VALS = '0; NEW_VALS = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    vec++;
    if ({Load, Shift, Busy, Done, Converged} !== 5'b0 || IterCount !== 16'd0 || MaxDelta !== 8'd0) begin
      miss++;
      $display("FAIL reset_outputs: got L%b S%b B%b D%b C%b it=%0d md=%0h, want all 0",
               Load, Shift, Busy, Done, Converged, IterCount, MaxDelta);
    end
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_converge_first;
    Threshold = 8'd0; MaxIter = 16'd10;
    OLD_VALS = 32'h40404040; NEW_VALS = 32'h40404040;
    run(20);
    vec++; if (first_load !== 1) begin miss++; $display("FAIL conv1_load_cycle: got %0d, want 1", first_load); end
    vec++; if (shift_n !== 1 || shift_cyc[0] !== 4) begin miss++; $display("FAIL conv1_shift: got n=%0d c=%0d, want n=1 c=4", shift_n, shift_cyc[0]); end
    vec++; if (done_cyc !== 6) begin miss++; $display("FAIL conv1_done_cycle: got %0d, want 6", done_cyc); end
    vec++; if (Converged !== 1'b1 || Busy !== 1'b0) begin miss++; $display("FAIL conv1_flags: got C=%b B=%b, want C=1 B=0", Converged, Busy); end
    vec++; if (IterCount !== 16'd1 || MaxDelta !== 8'h00) begin miss++; $display("FAIL conv1_counts: got it=%0d md=%0h, want it=1 md=0", IterCount, MaxDelta); end
  endtask

  // Restarts from DONE: cell deltas {3, 0xE0, 5, 0}, budget exhausted after 3.
  task automatic test_budget;
    Threshold = 8'h20; MaxIter = 16'd3;
    OLD_VALS = {8'h77, 8'h20, 8'h10, 8'h10};
    NEW_VALS = {8'h77, 8'h25, 8'hF0, 8'h13};
    run(40);
    vec++; if (first_load !== 1 || load_cnt !== 1) begin miss++; $display("FAIL budget_load: got first=%0d n=%0d, want 1 1", first_load, load_cnt); end
    vec++; if (shift_n !== 3 || shift_cyc[0] !== 4 || shift_cyc[1] !== 8 || shift_cyc[2] !== 12) begin
      miss++; $display("FAIL budget_shifts: got n=%0d %0d,%0d,%0d, want 3 at 4,8,12", shift_n, shift_cyc[0], shift_cyc[1], shift_cyc[2]);
    end
    vec++; if (done_cyc !== 14) begin miss++; $display("FAIL budget_done_cycle: got %0d, want 14", done_cyc); end
    vec++; if (Converged !== 1'b0 || IterCount !== 16'd3 || MaxDelta !== 8'hE0) begin
      miss++; $display("FAIL budget_result: got C=%b it=%0d md=%0h, want C=0 it=3 md=e0", Converged, IterCount, MaxDelta);
    end
  endtask

  task automatic test_boundary;
    Threshold = 8'd5; MaxIter = 16'd4;
    OLD_VALS = {8'h33, 8'h22, 8'h11, 8'h0A};
    NEW_VALS = {8'h33, 8'h22, 8'h11, 8'h05};
    run(20);
    vec++; if (done_cyc !== 6 || Converged !== 1'b1 || MaxDelta !== 8'd5 || IterCount !== 16'd1) begin
      miss++; $display("FAIL boundary_eq: got done=%0d C=%b md=%0d it=%0d, want 6 1 5 1", done_cyc, Converged, MaxDelta, IterCount);
    end
    Threshold = 8'd4; MaxIter = 16'd2;
    run(20);
    vec++; if (done_cyc !== 10 || Converged !== 1'b0 || MaxDelta !== 8'd5 || IterCount !== 16'd2) begin
      miss++; $display("FAIL boundary_above: got done=%0d C=%b md=%0d it=%0d, want 10 0 5 2", done_cyc, Converged, MaxDelta, IterCount);
    end
  endtask

  task automatic test_maxiter_zero;
    Threshold = 8'hFF; MaxIter = 16'd0;
    run(10);
    vec++; if (load_cnt !== 1 || shift_n !== 0) begin miss++; $display("FAIL zero_strobes: got load=%0d shift=%0d, want 1 0", load_cnt, shift_n); end
    vec++; if (done_cyc !== 2 || Converged !== 1'b0 || IterCount !== 16'd0) begin
      miss++; $display("FAIL zero_result: got done=%0d C=%b it=%0d, want 2 0 0", done_cyc, Converged, IterCount);
    end
  endtask

  task automatic test_abort;
    Threshold = 8'd0; MaxIter = 16'd10;
    OLD_VALS = {8'h00, 8'h00, 8'h10, 8'h00};
    NEW_VALS = {8'h00, 8'h00, 8'hF0, 8'h00};
    run(6);
    vec++; if (shift_n !== 1 || Busy !== 1'b1 || done_cyc !== -1) begin
      miss++; $display("FAIL abort_pre: got shifts=%0d B=%b done=%0d, want 1 1 -1", shift_n, Busy, done_cyc);
    end
    Abort = 1'b1; Start = 1'b1;
    @(posedge Clk); #1 Abort = 1'b0; Start = 1'b0;
    @(negedge Clk);
    vec++; if ({Load, Shift, Busy, Done, Converged} !== 5'b0 || IterCount !== 16'd1 || MaxDelta !== 8'hE0) begin
      miss++; $display("FAIL abort_state: got L%b S%b B%b D%b C%b it=%0d md=%0h, want 0s it=1 md=e0",
                       Load, Shift, Busy, Done, Converged, IterCount, MaxDelta);
    end
    shift_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (Shift || Load || Busy) shift_n++;
    end
    vec++; if (shift_n !== 0 || IterCount !== 16'd1) begin miss++; $display("FAIL abort_idle: got activity=%0d it=%0d, want 0 1", shift_n, IterCount); end
  endtask

  task automatic test_reset_midrun;
    run(8);
    vec++; if (Shift !== 1'b1 || IterCount !== 16'd1) begin miss++; $display("FAIL rst_pre: got S=%b it=%0d, want 1 1", Shift, IterCount); end
    #2 Reset = 1'b0;
    #1;
    vec++; if ({Load, Shift, Busy, Done, Converged} !== 5'b0 || IterCount !== 16'd0 || MaxDelta !== 8'd0) begin
      miss++; $display("FAIL rst_async: got L%b S%b B%b D%b C%b it=%0d md=%0h, want all 0",
                       Load, Shift, Busy, Done, Converged, IterCount, MaxDelta);
    end
    @(posedge Clk); #1;
    vec++; if (Load !== 1'b0 || Shift !== 1'b0) begin miss++; $display("FAIL rst_hold: got L%b S%b, want 0 0", Load, Shift); end
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk);
    OLD_VALS = 32'h40404040; NEW_VALS = 32'h40404040;
    run(20);
    vec++; if (first_load !== 1 || done_cyc !== 6 || Converged !== 1'b1 || IterCount !== 16'd1) begin
      miss++; $display("FAIL rst_restart: got load=%0d done=%0d C=%b it=%0d, want 1 6 1 1", first_load, done_cyc, Converged, IterCount);
    end
  endtask

  initial begin
    test_reset;
    test_converge_first;
    test_budget;
    test_boundary;
    test_maxiter_zero;
    test_abort;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
